trng_seq_ctrl: RTL
==================

# trng_seq_ctrl

Sequencer and access arbiter for the TRNG 256-bit data buffer. It powers up the entropy source, waits out a warm-up period, and gates source bits into the buffer. When the buffer fills, it hands the buffer to the post-processing engine, then publishes the result to software. CPU word accesses to the buffer are granted only while the engine does not own it.

## Interface
- CNT_W, 20: width of the shared warm-up/timeout counter.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- ctrl_en  in  1  global enable; level.
- trng_drng_sel  in  1  0 = TRNG (source fills buffer), 1 = DRNG (CPU writes seed).
- cfg_warmup  in  CNT_W  warm-up cycles after src_en rises.
- cfg_timeout  in  CNT_W  max COLLECT cycles in TRNG mode; 0 disables.
- src_en  out  1  entropy source enable.
- src_vld  in  1  raw source bit valid.
- buf_vld  out  1  gated valid to buffer digi_data_vld.
- buf_ready  in  1  buffer full flag.
- post_read  out  1  one-cycle pulse; clears buffer count/ready.
- pp_req  out  1  post-processing request; level until pp_done.
- pp_done  in  1  one-cycle pulse from engine.
- rng_valid  out  1  result available to software.
- rng_ack  in  1  software consumed result; pulse.
- cpu_req, cpu_wr  in  1  CPU buffer access request / write qualifier.
- cpu_addr  in  3  word address; cpu_wdata  in  32  write data.
- cpu_gnt  out  1  access granted this cycle.
- buf_read, buf_write  out  1  to buffer; buf_addr  out  3; buf_datain  out  32.
- tmo_err  out  1  sticky timeout error; err_clr  in  1  clear pulse.
- state_o  out  3  current state (debug).

## Operation
- States: IDLE(0), WARMUP(1), COLLECT(2), PROCESS(3), HOLD(4), ERROR(5).
- IDLE: ctrl_en=1 -> WARMUP if trng_drng_sel=0 (src_en<=1, counter<=cfg_warmup), else -> COLLECT.
- WARMUP: counter decrements each cycle; at 0 -> COLLECT. cfg_warmup=0 -> exactly one WARMUP cycle.
- COLLECT: counter cleared on entry, increments saturating.
  - buf_ready=1 -> PROCESS.
  - Else TRNG mode, cfg_timeout!=0, and counter==cfg_timeout -> ERROR, tmo_err<=1, src_en<=0.
- PROCESS: pp_req=1; on pp_done -> HOLD, post_read pulse, rng_valid<=1.
- HOLD: rng_ack -> rng_valid<=0 -> COLLECT. src_en stays 1 in TRNG mode.
- ERROR: err_clr -> IDLE, tmo_err<=0.
- buf_vld = src_vld & ~trng_drng_sel & (state==COLLECT) & ~buf_ready; never asserted otherwise.
- Arbitration: cpu_gnt = cpu_req & (state!=PROCESS).
  - Granted: buf_read = ~cpu_wr; buf_write = cpu_wr & trng_drng_sel.
  - buf_addr/buf_datain pass cpu_addr/cpu_wdata; denied requests must be held by the CPU.
- Precedence (high to low):
  - reset;
  - ctrl_en=0 or trng_drng_sel toggle: -> IDLE next cycle, src_en/pp_req/rng_valid<=0, post_read pulse if leaving PROCESS/HOLD; tmo_err kept;
  - buf_ready over timeout in the same cycle;
  - pp_done.
- rng_ack outside HOLD and err_clr outside ERROR are ignored.

## Timing
- Reset: state IDLE, src_en=0, pp_req=0, post_read=0, rng_valid=0, tmo_err=0, counter=0; buf_vld=0; cpu_gnt follows cpu_req.
- State changes take effect 1 cycle after the qualifying input is sampled; registered outputs update with the state.
- ctrl_en rise -> src_en=1 next cycle; COLLECT entered cfg_warmup+1 cycles after WARMUP entry.
- buf_ready high -> pp_req high next cycle.
- pp_done -> post_read and rng_valid high next cycle; post_read lasts exactly 1 cycle.
- cpu_gnt, buf_read, buf_write, buf_vld are combinational, with zero latency.
- Timeout fires on the cycle the counter equals cfg_timeout: ERROR is entered cfg_timeout+1 cycles after COLLECT entry.

## Structure
- Shared package trng_ctrl_pkg: state encoding constants (IDLE..ERROR) and BUF_LAST_ADDR=3'd7.
- Sub-module trng_seq_cnt: loadable down/up saturating CNT_W counter, shared by warm-up and timeout. The FSM and arbiter stay in the top.

## Test plan
- TRNG flow: cfg_warmup=4, ctrl_en=1, src_vld always 1, buffer model full after 256 bits.
  - src_en rises at cycle 1; buf_vld first high at cycle 6.
  - pp_req follows buf_ready by 1 cycle; pp_done -> one post_read pulse and rng_valid=1.
  - rng_ack -> back to COLLECT.
- Timeout: cfg_timeout=100, buf_ready never set -> tmo_err=1 and src_en=0 exactly 101 cycles after COLLECT entry. err_clr -> IDLE.
- Arbitration: cpu_req read addr 7 during PROCESS -> cpu_gnt=0, buf_read=0. Same request in HOLD -> granted immediately.
- DRNG: trng_drng_sel=1, eight CPU writes addr 0..7 -> no WARMUP, src_en=0, buf_vld=0. PROCESS follows the final write's buf_ready.
- Abort: ctrl_en=0 mid-PROCESS -> IDLE next cycle with pp_req=0, one post_read pulse, rng_valid=0. A pp_done in the same cycle is ignored.
- Collision: buf_ready and timeout match in the same cycle -> PROCESS entered, tmo_err stays 0. Async rstn mid-COLLECT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/trng_ctrl_pkg.sv
// ============================================================================
// trng_ctrl_pkg : shared state encoding and buffer constants for the TRNG sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package trng_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WARMUP  = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_PROCESS = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;
    localparam logic [2:0] ST_ERROR   = 3'd5;

    localparam logic [2:0] BUF_LAST_ADDR = 3'd7;

endpackage

`default_nettype wire

// File: rtl/trng_seq_cnt.sv
// ============================================================================
// trng_seq_cnt : loadable saturating up/down counter (warm-up and timeout)
// Revision: 1.0
// ============================================================================
`default_nettype none

module trng_seq_cnt #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_ONE;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trng_seq_ctrl.sv
// ============================================================================
// trng_seq_ctrl : TRNG buffer sequencer (warm-up/collect/process/hold) and CPU arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module trng_seq_ctrl
    import trng_ctrl_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             ctrl_en,
    input  logic             trng_drng_sel,
    input  logic [CNT_W-1:0] cfg_warmup,
    input  logic [CNT_W-1:0] cfg_timeout,
    output logic             src_en,
    input  logic             src_vld,
    output logic             buf_vld,
    input  logic             buf_ready,
    output logic             post_read,
    output logic             pp_req,
    input  logic             pp_done,
    output logic             rng_valid,
    input  logic             rng_ack,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [2:0]       cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             cpu_gnt,
    output logic             buf_read,
    output logic             buf_write,
    output logic [2:0]       buf_addr,
    output logic [31:0]      buf_datain,
    output logic             tmo_err,
    input  logic             err_clr,
    output logic [2:0]       state_o
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             sel_q;
    logic             abort;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_inc;
    logic             src_en_nxt;
    logic             pp_req_nxt;
    logic             rng_valid_nxt;
    logic             post_read_nxt;
    logic             tmo_err_nxt;

    trng_seq_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cfg_warmup),
        .dec      (cnt_dec),
        .inc      (cnt_inc),
        .cnt      (cnt)
    );

    // A mode change mid-flow is treated like a disable: everything returns to IDLE.
    assign abort       = ~ctrl_en | (trng_drng_sel != sel_q);
    assign timeout_hit = ~trng_drng_sel & (cfg_timeout != '0) & (cnt == cfg_timeout);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            sel_q     <= 1'b0;
            src_en    <= 1'b0;
            pp_req    <= 1'b0;
            rng_valid <= 1'b0;
            post_read <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_q     <= trng_drng_sel;
            src_en    <= src_en_nxt;
            pp_req    <= pp_req_nxt;
            rng_valid <= rng_valid_nxt;
            post_read <= post_read_nxt;
            tmo_err   <= tmo_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = trng_drng_sel ? ST_COLLECT : ST_WARMUP;
                ST_WARMUP:  if (cnt == '0) state_nxt = ST_COLLECT;
                ST_COLLECT: begin
                    if (buf_ready)        state_nxt = ST_PROCESS;
                    else if (timeout_hit) state_nxt = ST_ERROR;
                end
                ST_PROCESS: if (pp_done) state_nxt = ST_HOLD;
                ST_HOLD:    if (rng_ack) state_nxt = ST_COLLECT;
                ST_ERROR:   if (err_clr) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        src_en_nxt    = ~trng_drng_sel &
                        ((state_nxt == ST_WARMUP) | (state_nxt == ST_COLLECT) |
                         (state_nxt == ST_PROCESS) | (state_nxt == ST_HOLD));
        pp_req_nxt    = (state_nxt == ST_PROCESS);
        rng_valid_nxt = (state_nxt == ST_HOLD);
        // Buffer is released on PROCESS exit, or when HOLD is aborted before software acks.
        post_read_nxt = ((state == ST_PROCESS) & (state_nxt != ST_PROCESS)) |
                        ((state == ST_HOLD) & (state_nxt == ST_IDLE));
        tmo_err_nxt   = tmo_err;
        if ((state == ST_COLLECT) && (state_nxt == ST_ERROR)) begin
            tmo_err_nxt = 1'b1;
        end else if ((state == ST_ERROR) && !abort && err_clr) begin
            tmo_err_nxt = 1'b0;
        end

        cnt_clr  = (state_nxt == ST_IDLE) | ((state_nxt == ST_COLLECT) & (state != ST_COLLECT));
        cnt_load = (state_nxt == ST_WARMUP) & (state != ST_WARMUP);
        cnt_dec  = (state == ST_WARMUP) & (state_nxt == ST_WARMUP);
        cnt_inc  = (state == ST_COLLECT) & (state_nxt == ST_COLLECT);

        buf_vld    = src_vld & ~trng_drng_sel & (state == ST_COLLECT) & ~buf_ready;
        cpu_gnt    = cpu_req & (state != ST_PROCESS);
        buf_read   = cpu_gnt & ~cpu_wr;
        buf_write  = cpu_gnt & cpu_wr & trng_drng_sel;
        buf_addr   = cpu_addr;
        buf_datain = cpu_wdata;
        state_o    = state;
    end

endmodule

`default_nettype wire
